mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have no parameters; 2 requester ports and 32-bit address/data are fixed.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pN_req  in  1  (N=0,1) access request; held until pN_gnt seen, then dropped for one or more cycles unless a new access is intended.
REQ-005 pN_we  in  1  write (1) or read (0); sampled with pN_req.
REQ-006 pN_addr  in  32  byte address; sampled with pN_req.
REQ-007 pN_wdata  in  32  write data; sampled with pN_req.
REQ-008 pN_gnt  out  1  one-cycle pulse: request accepted and latched.
REQ-009 pN_rvalid  out  1  one-cycle pulse: access complete; read data valid.
REQ-010 pN_rdata  out  32  read data; valid only while pN_rvalid=1.
REQ-011 mem_address  out  32  address to the shared single-port memory.
REQ-012 mem_data_out  out  32  write data to memory.
REQ-013 mem_we  out  1  memory write enable.
REQ-014 mem_data_in  in  32  memory read data, valid one cycle after the address is presented.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 owner  out  1  index of the port owning the current or last access.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-018 IDLE: if any pN_req=1 at a clock edge, winner latched, next state ACCESS; otherwise stay IDLE.
REQ-019 Winner selection SHALL be round-robin: single requester wins outright; with both requesting, the port not served last wins; after reset port 0 has priority.
REQ-020 At the accepting edge, winner addr/we/wdata SHALL be registered into mem_address/mem_data_out/mem_we and owner SHALL update.
REQ-021 ACCESS (exactly 1 cycle): mem_we = latched we; pOwner_gnt=1; other port gnt=0; next state RESP.
REQ-022 RESP (exactly 1 cycle): mem_we=0; pOwner_rvalid=1; pOwner_rdata=mem_data_in for reads, 32'h0 for writes.
REQ-023 From RESP: if any pN_req=1 at the edge, arbitration per REQ-019 and next state ACCESS (back-to-back, one access per 2 cycles); otherwise IDLE.
REQ-024 Request sampling SHALL occur only at edges leaving IDLE or RESP; req toggling during ACCESS SHALL be ignored.
REQ-025 A requester still holding pN_req in RESP SHALL be treated as a new request.
REQ-026 Outside ACCESS, mem_we SHALL be 0; mem_address and mem_data_out SHALL hold their last values.
REQ-027 At most one pN_gnt and one pN_rvalid SHALL be high in any cycle; non-owner outputs SHALL be 0.
REQ-028 Exactly one rvalid per gnt, 1 cycle after it; request-to-rvalid latency is 3 cycles from IDLE.

Reset
REQ-029 With reset=1 at an edge: state IDLE, round-robin pointer to port 0, owner=0, mem_address=0, mem_data_out=0, mem_we=0, all gnt/rvalid=0, all rdata=0, busy=0.
REQ-030 Reset asserted in ACCESS or RESP SHALL abort the access; no rvalid is emitted for it.
REQ-031 A request held during reset SHALL be arbitrated at the first edge after reset deasserts.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (IDLE=0, ACCESS=1, RESP=2) and the port-count constant.
REQ-033 Winner selection SHALL be a combinational sub-module rr_arbiter_2 (inputs req[1:0], last; output winner, valid).
REQ-034 FSM, latches and output muxing SHALL remain in mem_arbiter.

Verification
REQ-035 p0 read addr 0x100, memory returns 0xDEADBEEF -> p0_gnt in cycle 2 with mem_address=0x100 and mem_we=0; p0_rvalid in cycle 3 with rdata=0xDEADBEEF.
REQ-036 p1 write addr 0x40 data 0x12345678 -> mem_we=1 for exactly one cycle with those values; p1_rvalid pulse with rdata=0.
REQ-037 Both ports request continuously after reset -> grants alternate 0,1,0,1, one grant per 2 cycles, and never two gnt in one cycle.
REQ-038 Reset asserted during ACCESS of p0 read -> next cycle busy=0, mem_we=0, and no p0_rvalid.
REQ-039 p0 requests once, then p0 and p1 request in the same RESP cycle -> p1 wins the next arbitration.
REQ-040 p0_req dropped during ACCESS -> access completes normally, and no further grant follows.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM encoding and port count for the memory arbiter.
package mem_arbiter_pkg;
  localparam int NUM_PORTS = 2;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/mem_arbiter_rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin winner select; on contention the port not served last wins.
module rr_arbiter_2
  import mem_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last,
  output logic                 winner,
  output logic                 valid
);
  assign valid  = |req;
  assign winner = (&req) ? ~last : req[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin front end to a shared single-port memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_out,
  output logic        mem_we,
  input  logic [31:0] mem_data_in,
  output logic        busy,
  output logic        owner
);
  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        win, win_valid, accept, in_access, in_resp;
  rr_arbiter_2 u_rr (
    .req    ({p1_req, p0_req}),
    .last   (~prio_q),
    .winner (win),
    .valid  (win_valid)
  );
  // requests are only sampled on edges leaving IDLE or RESP
  assign accept = win_valid && (state_q != ACCESS);
  always_comb begin
    state_d = (state_q == ACCESS) ? RESP : (win_valid ? ACCESS : IDLE);
    prio_d  = accept ? ~win : prio_q;
    owner_d = accept ? win : owner_q;
    we_d    = accept ? (win ? p1_we : p0_we) : we_q;
    addr_d  = accept ? (win ? p1_addr : p0_addr) : addr_q;
    wdata_d = accept ? (win ? p1_wdata : p0_wdata) : wdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign in_access    = state_q == ACCESS;
  assign in_resp      = state_q == RESP;
  assign busy         = state_q != IDLE;
  assign owner        = owner_q;
  assign mem_address  = addr_q;
  assign mem_data_out = wdata_q;
  assign mem_we       = in_access & we_q;
  assign p0_gnt       = in_access & ~owner_q;
  assign p1_gnt       = in_access & owner_q;
  assign p0_rvalid    = in_resp & ~owner_q;
  assign p1_rvalid    = in_resp & owner_q;
  // writes answer with zero data
  assign p0_rdata     = (p0_rvalid & ~we_q) ? mem_data_in : '0;
  assign p1_rdata     = (p1_rvalid & ~we_q) ? mem_data_in : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a transaction-schedule model checked every cycle.
module tb_mem_arbiter;
  logic        clk = 0, reset = 1;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0, mem_rd = 0;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_we, busy, owner;
  logic [31:0] p0_rdata, p1_rdata, mem_address, mem_data_out;
  int checks = 0, errors = 0;
  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_we(mem_we),
    .mem_data_in(mem_rd), .busy(busy), .owner(owner)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask
  // model: each accepted access occupies the edge it is taken on plus one; grant shows in the
  // cycle after the accepting edge, response in the next, and the next accept is two edges later
  int cyc = 0, acc_cyc = -10, free_at = 0, prio = 0;
  int m_own = 0;
  logic m_we = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      acc_cyc = -10; free_at = 0; prio = 0; m_own = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    end else if (cyc >= free_at && (p0_req || p1_req)) begin
      m_own   = (p0_req && p1_req) ? prio : (p1_req ? 1 : 0);
      prio    = 1 - m_own;
      m_we    = m_own == 1 ? p1_we : p0_we;
      m_addr  = m_own == 1 ? p1_addr : p0_addr;
      m_wdata = m_own == 1 ? p1_wdata : p0_wdata;
      acc_cyc = cyc;
      free_at = cyc + 2;
    end
  end
  always @(negedge clk) begin
    if (cyc > 0) begin
      logic g, r;
      logic [31:0] rd;
      g  = cyc == acc_cyc;
      r  = cyc == acc_cyc + 1;
      rd = m_we ? 32'h0 : mem_rd;
      chk("p0_gnt", {31'b0, p0_gnt}, {31'b0, g && m_own == 0});
      chk("p1_gnt", {31'b0, p1_gnt}, {31'b0, g && m_own == 1});
      chk("p0_rvalid", {31'b0, p0_rvalid}, {31'b0, r && m_own == 0});
      chk("p1_rvalid", {31'b0, p1_rvalid}, {31'b0, r && m_own == 1});
      chk("p0_rdata", p0_rdata, (r && m_own == 0) ? rd : 32'h0);
      chk("p1_rdata", p1_rdata, (r && m_own == 1) ? rd : 32'h0);
      chk("mem_we", {31'b0, mem_we}, {31'b0, g && m_we});
      chk("busy", {31'b0, busy}, {31'b0, g || r});
      chk("owner", {31'b0, owner}, m_own);
      chk("mem_address", mem_address, m_addr);
      chk("mem_data_out", mem_data_out, m_wdata);
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  initial begin
    int seq[$];
    tick(); tick();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_addr", mem_address, 0);
    reset = 0;
    // p0 read of 0x100
    mem_rd = 32'hDEADBEEF;
    p0_req = 1; p0_we = 0; p0_addr = 32'h100;
    tick();
    chk("t1_gnt", {31'b0, p0_gnt}, 1);
    chk("t1_addr", mem_address, 32'h100);
    chk("t1_we", {31'b0, mem_we}, 0);
    p0_req = 0;
    tick();
    chk("t1_rvalid", {31'b0, p0_rvalid}, 1);
    chk("t1_rdata", p0_rdata, 32'hDEADBEEF);
    tick();
    chk("t1_idle", {31'b0, busy}, 0);
    // p1 write
    p1_req = 1; p1_we = 1; p1_addr = 32'h40; p1_wdata = 32'h12345678;
    tick();
    chk("t2_gnt", {31'b0, p1_gnt}, 1);
    chk("t2_we", {31'b0, mem_we}, 1);
    chk("t2_addr", mem_address, 32'h40);
    chk("t2_data", mem_data_out, 32'h12345678);
    p1_req = 0;
    tick();
    chk("t2_we_off", {31'b0, mem_we}, 0);
    chk("t2_rvalid", {31'b0, p1_rvalid}, 1);
    chk("t2_rdata", p1_rdata, 0);
    tick();
    // both requesting continuously after reset
    reset = 1; tick(); reset = 0;
    p0_req = 1; p1_req = 1; p1_we = 0; p1_addr = 32'h200; mem_rd = 32'hA5A5_0001;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t3_one_gnt", {31'b0, p0_gnt & p1_gnt}, 0);
      if (p0_gnt) seq.push_back(0);
      if (p1_gnt) seq.push_back(1);
    end
    chk("t3_count", seq.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_order", i < seq.size() ? seq[i] : 9, i % 2);
    p0_req = 0; p1_req = 0;
    tick(); tick(); tick();
    // reset during ACCESS of a p0 read
    p0_req = 1; p0_addr = 32'h300;
    tick();
    chk("t4_gnt", {31'b0, p0_gnt}, 1);
    reset = 1; p0_req = 0;
    tick();
    chk("t4_busy", {31'b0, busy}, 0);
    chk("t4_we", {31'b0, mem_we}, 0);
    chk("t4_rvalid", {31'b0, p0_rvalid}, 0);
    reset = 0;
    tick();
    // p0 alone, then both in the RESP cycle: p1 must win
    p0_req = 1; p0_addr = 32'h10;
    tick();
    chk("t5_gnt0", {31'b0, p0_gnt}, 1);
    p0_req = 0;
    tick();
    p0_req = 1; p1_req = 1; p1_addr = 32'h20;
    tick();
    chk("t5_p1_wins", {31'b0, p1_gnt}, 1);
    chk("t5_p0_lose", {31'b0, p0_gnt}, 0);
    p0_req = 0; p1_req = 0;
    tick(); tick();
    // p0 drops req during ACCESS
    p0_req = 1; p0_we = 1; p0_addr = 32'h44; p0_wdata = 32'hCAFE_F00D;
    tick();
    chk("t6_gnt", {31'b0, p0_gnt}, 1);
    p0_req = 0;
    tick();
    chk("t6_rvalid", {31'b0, p0_rvalid}, 1);
    tick();
    chk("t6_no_gnt", {31'b0, p0_gnt}, 0);
    chk("t6_idle", {31'b0, busy}, 0);
    // request held through reset is taken at the first edge after release
    reset = 1; p1_req = 1; p1_we = 1; p1_wdata = 32'h5555_AAAA;
    tick(); tick();
    reset = 0;
    tick();
    chk("t7_gnt", {31'b0, p1_gnt}, 1);
    chk("t7_data", mem_data_out, 32'h5555_AAAA);
    p1_req = 0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
